data_sram_ctrl: RTL and testbench
=================================

Name: data_sram_ctrl

Overview:
Sequences load/store accesses from the MEM stage onto a data SRAM port with a split address/data handshake (req/addr_ok/data_ok). Holds the pipeline with stallreq while an access is outstanding. Generates byte strobes and replicated write data for sb/sh/sw, and sign/zero-extends lb/lbu/lh/lhu/lw results. Includes alignment checking and a watchdog timeout. It sits between the MEM stage and the data SRAM interface, and its stallreq feeds the pipeline stall controller.

Parameters:
TIMEOUT_CYC, 255, maximum cycles spent in ADDR+DATA before the access is aborted (range 2..65535)
CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_req  in  1  MEM stage requests an access this cycle
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
mem_sign  in  1  load sign-extend enable (lb/lh)
mem_addr  in  32  byte address
mem_wdata  in  32  store data, right-aligned
mem_hold  in  1  downstream stall; keeps the DONE result presented
stallreq  out  1  pipeline stall request
rdata_out  out  32  extended load result
rdata_valid  out  1  rdata_out valid / access complete
addr_err  out  1  misaligned access pulse
bus_err  out  1  watchdog timeout pulse
data_sram_req  out  1  SRAM request
data_sram_wr  out  1  SRAM write
data_sram_wstrb  out  4  byte strobes
data_sram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
data_sram_wdata  out  32  lane-replicated write data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  read data valid / write complete
data_sram_rdata  in  32  read data

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE. After rst: IDLE, all registered outputs 0, counter 0.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - mem_req & aligned: latch we/size/sign/addr/wdata; next state ADDR.
  - mem_req & misaligned: addr_err=1 combinationally in that cycle; no SRAM access; stay IDLE.
- stallreq = (IDLE & mem_req & aligned) | ADDR | DATA. stallreq is 0 in DONE and on misaligned requests.
- ADDR: data_sram_req=1, driven from latched values.
  - addr_ok & data_ok in the same cycle: go to DONE.
  - addr_ok only: go to DATA; data_sram_req drops the next cycle.
- DATA: data_sram_req=0. On data_ok: capture the extended load result (0 for stores) into the result register; go to DONE.
- DONE: rdata_valid=1, rdata_out = result register. If mem_hold, stay in DONE; else go to IDLE. A new mem_req is not accepted in DONE.
- Minimum latency: request in cycle T, addr_ok and data_ok in T+1, rdata_valid in T+2.
- Store strobes and data:
  - sb: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 1111; wdata = wdata.
  - Loads: wstrb = 0000.
- Load extension: select the byte/half lane by latched addr[1:0]. Sign-extend if mem_sign, else zero-extend. Word loads pass through.
- Watchdog:
  - Counter clears on entering ADDR and increments each cycle in ADDR or DATA.
  - If it reaches TIMEOUT_CYC without data_ok: bus_err=1 for one cycle, go to DONE with result 0.
  - A late data_ok that arrives in IDLE or DONE is ignored.
- rst in any state forces IDLE on the next edge and drops data_sram_req immediately (registered). Outstanding SRAM responses are ignored afterwards.
- data_ok in ADDR without addr_ok is ignored.

Decomposition:
- Shared defines header: size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings, and the SRAM handshake bus width.
- One sub-module, data_lane_fmt (combinational), handles strobe/data replication for stores and lane select/extension for loads. The FSM and watchdog stay in the top module.

Test Plan:
- lb at 0x1003, rdata 0x80FF_0000, addr_ok+data_ok on the first ADDR cycle -> wstrb 0000, rdata_out 0xFFFF_FF80, rdata_valid at T+2, stallreq high for T..T+1.
- sh at 0x2002 with wdata 0x0000_ABCD -> data_sram_addr 0x2000, wstrb 1100, wdata 0xABCD_ABCD; addr_ok after 2 wait cycles, data_ok 3 cycles later -> stallreq high for exactly 6 cycles.
- lw at 0x3001 -> addr_err pulse in the same cycle, data_sram_req never asserts, stallreq 0.
- lhu at 0x4002, rdata 0x8001_1234, mem_hold=1 for 3 cycles in DONE -> rdata_out stays 0x0000_8001 with rdata_valid high for 4 cycles, then IDLE.
- TIMEOUT_CYC=8, addr_ok given but data_ok never arrives -> bus_err pulse 8 cycles after entering ADDR, rdata_out 0; a data_ok injected 2 cycles later is ignored.
- rst asserted while in DATA -> next cycle IDLE, stallreq 0, data_sram_req 0; a following lw at 0x5000 completes normally.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data SRAM controller.
// - Access size encodings presented by the MEM stage.
// - FSM state encodings for the access sequencer.
// - Data width of the SRAM handshake bus.
// - Helper that flags misaligned half/word accesses.
package data_sram_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;  // 2'b11 is treated as a word

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int SRAM_DW = 32;

  // Bytes are never misaligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_lane_fmt.sv
// Byte-lane formatter for the data SRAM controller (purely combinational).
// Ports:
//   size_i, sign_i, we_i, addr_lo_i : latched access attributes
//   wdata_i                         : right-aligned store data
//   rdata_i                         : raw SRAM read word
//   wstrb_o                         : byte strobes (0000 for loads)
//   wdata_o                         : store data replicated across lanes
//   rdata_o                         : lane-selected, extended load result (0 for stores)
module data_lane_fmt
  import data_sram_ctrl_pkg::*;
(
  input  logic [1:0]         size_i,
  input  logic               sign_i,
  input  logic               we_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [SRAM_DW-1:0] wdata_i,
  input  logic [SRAM_DW-1:0] rdata_i,
  output logic [3:0]         wstrb_o,
  output logic [SRAM_DW-1:0] wdata_o,
  output logic [SRAM_DW-1:0] rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = '0;
    if (we_i) begin
      case (size_i)
        SZ_B: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_H: begin
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: wstrb_o = 4'b1111;
      endcase
    end else begin
      case (size_i)
        SZ_B:    rdata_o = {{24{sign_i & ld_byte[7]}}, ld_byte};
        SZ_H:    rdata_o = {{16{sign_i & ld_half[15]}}, ld_half};
        default: rdata_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_ctrl.sv
// Data SRAM controller: sequences MEM-stage loads/stores onto an SRAM port
// with a split address/data handshake, stalls the pipeline while an access
// is outstanding, and aborts accesses that exceed a watchdog budget.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mem_req/we/size/sign/addr/wdata : access request from MEM stage
//   mem_hold                 : keep the completed result presented
//   stallreq                 : pipeline stall request
//   rdata_out, rdata_valid   : extended load result / completion
//   addr_err, bus_err        : misalignment pulse, watchdog timeout pulse
//   data_sram_*              : SRAM request/response interface
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [1:0]         mem_size,
  input  logic               mem_sign,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_hold,
  output logic               stallreq,
  output logic [31:0]        rdata_out,
  output logic               rdata_valid,
  output logic               addr_err,
  output logic               bus_err,
  output logic               data_sram_req,
  output logic               data_sram_wr,
  output logic [3:0]         data_sram_wstrb,
  output logic [31:0]        data_sram_addr,
  output logic [SRAM_DW-1:0] data_sram_wdata,
  input  logic               data_sram_addr_ok,
  input  logic               data_sram_data_ok,
  input  logic [SRAM_DW-1:0] data_sram_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  logic [1:0]         state_q, state_d;
  logic               we_q, sign_q;
  logic [1:0]         size_q;
  logic [31:0]        addr_q, wdata_q;
  logic [31:0]        result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               bus_err_q, bus_err_d;
  logic               misaligned, accept, timeout_hit;
  logic [SRAM_DW-1:0] lane_rdata;

  assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
  assign accept     = (state_q == ST_IDLE) && mem_req && !misaligned;

  // The counter value after this cycle; hitting the limit means this was the
  // last ADDR/DATA cycle allowed.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == TIMEOUT_LIM);

  data_lane_fmt u_lane_fmt (
    .size_i    (size_q),
    .sign_i    (sign_q),
    .we_i      (we_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (data_sram_rdata),
    .wstrb_o   (data_sram_wstrb),
    .wdata_o   (data_sram_wdata),
    .rdata_o   (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        cnt_d = cnt_inc;
        // data_ok without addr_ok is not a valid response here.
        if (data_sram_addr_ok && data_sram_data_ok) begin
          state_d  = ST_DONE;
          result_d = lane_rdata;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          result_d  = '0;
          bus_err_d = 1'b1;
        end else if (data_sram_addr_ok) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_inc;
        if (data_sram_data_ok) begin
          state_d  = ST_DONE;
          result_d = lane_rdata;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          result_d  = '0;
          bus_err_d = 1'b1;
        end
      end
      default: begin
        if (!mem_hold) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      if (accept) begin
        we_q    <= mem_we;
        sign_q  <= mem_sign;
        size_q  <= mem_size;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  assign stallreq       = accept || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign addr_err       = (state_q == ST_IDLE) && mem_req && misaligned;
  assign rdata_valid    = (state_q == ST_DONE);
  assign rdata_out      = result_q;
  assign bus_err        = bus_err_q;
  assign data_sram_req  = (state_q == ST_ADDR);
  assign data_sram_wr   = (state_q == ST_ADDR) && we_q;
  assign data_sram_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl. Inputs change on the falling edge; outputs
// are sampled 1 time unit later, well away from the rising edge.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_sign = 1'b0, mem_hold = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        stallreq, rdata_valid, addr_err, bus_err;
  logic [31:0] rdata_out;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_sram_ctrl #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_hold(mem_hold),
    .stallreq(stallreq), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .bus_err(bus_err),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rdata_valid); end
    checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", data_sram_req); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_out); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    @(negedge clk); rst = 1'b0;
    $display("reset done");
  endtask

  // lb at 0x1003 with immediate addr_ok+data_ok: result at T+2
  task automatic test_lb_min_latency();
    @(negedge clk);  // T
    mem_req = 1; mem_we = 0; mem_size = 2'b00; mem_sign = 1; mem_addr = 32'h1003;
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_T: got %b want 1", stallreq); end
    @(negedge clk);  // T+1
    mem_req = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_0000;
    #1;
    checks++; if (data_sram_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %b want 1", data_sram_req); end
    checks++; if (data_sram_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", data_sram_addr); end
    checks++; if (data_sram_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_wstrb: got %b want 0000", data_sram_wstrb); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_T1: got %b want 1", stallreq); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL lb_valid_T1: got %b want 0", rdata_valid); end
    @(negedge clk);  // T+2
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
    #1;
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL lb_valid_T2: got %b want 1", rdata_valid); end
    checks++; if (rdata_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", rdata_out); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lb_stall_T2: got %b want 0", stallreq); end
    @(negedge clk);  // T+3
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL lb_valid_T3: got %b want 0", rdata_valid); end
    $display("lb 0x1003 rdata_out=%h", 32'hFFFF_FF80);
  endtask

  // sh at 0x2002; addr_ok in T+2, data_ok in T+5 -> stallreq over T..T+5
  task automatic test_sh_waits();
    int stall_cnt = 0;
    @(negedge clk);  // T
    mem_req = 1; mem_we = 1; mem_size = 2'b01; mem_sign = 0; mem_addr = 32'h2002; mem_wdata = 32'h0000_ABCD;
    #1; stall_cnt += int'(stallreq);
    @(negedge clk);  // T+1
    mem_req = 0; mem_we = 0; mem_wdata = 0;
    #1; stall_cnt += int'(stallreq);
    checks++; if (data_sram_addr !== 32'h2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", data_sram_addr); end
    checks++; if (data_sram_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", data_sram_wstrb); end
    checks++; if (data_sram_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", data_sram_wdata); end
    checks++; if (data_sram_wr !== 1'b1) begin errors++; $display("FAIL sh_wr: got %b want 1", data_sram_wr); end
    @(negedge clk);  // T+2
    data_sram_addr_ok = 1;
    #1; stall_cnt += int'(stallreq);
    checks++; if (data_sram_req !== 1'b1) begin errors++; $display("FAIL sh_req_T2: got %b want 1", data_sram_req); end
    @(negedge clk);  // T+3
    data_sram_addr_ok = 0;
    #1; stall_cnt += int'(stallreq);
    checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL sh_req_T3: got %b want 0", data_sram_req); end
    @(negedge clk);  // T+4
    #1; stall_cnt += int'(stallreq);
    @(negedge clk);  // T+5
    data_sram_data_ok = 1;
    #1; stall_cnt += int'(stallreq);
    @(negedge clk);  // T+6
    data_sram_data_ok = 0;
    #1; stall_cnt += int'(stallreq);
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL sh_valid: got %b want 1", rdata_valid); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h want 0", rdata_out); end
    @(negedge clk);  // T+7
    #1; stall_cnt += int'(stallreq);
    checks++; if (stall_cnt !== 6) begin errors++; $display("FAIL sh_stall_cycles: got %0d want 6", stall_cnt); end
    $display("sh 0x2002 stall_cycles=%0d", stall_cnt);
  endtask

  // Misaligned lw: addr_err pulse, no SRAM request, no stall
  task automatic test_misaligned();
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h3001;
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_addr_err: got %b want 1", addr_err); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", stallreq); end
    @(negedge clk);
    mem_req = 0;
    #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_addr_err_clr: got %b want 0", addr_err); end
    checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", data_sram_req); end
    $display("lw 0x3001 rejected");
  endtask

  // lhu at 0x4002 with mem_hold for 3 DONE cycles
  task automatic test_hold();
    @(negedge clk);  // T
    mem_req = 1; mem_we = 0; mem_size = 2'b01; mem_sign = 0; mem_addr = 32'h4002;
    @(negedge clk);  // T+1
    mem_req = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h8001_1234;
    for (int i = 0; i < 4; i++) begin  // T+2..T+5
      @(negedge clk);
      data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 32'h0;
      mem_hold = (i < 3);
      #1;
      checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rdata_valid); end
      checks++; if (rdata_out !== 32'h0000_8001) begin errors++; $display("FAIL hold_rdata[%0d]: got %h want 00008001", i, rdata_out); end
    end
    @(negedge clk);  // T+6
    mem_hold = 0;
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", rdata_valid); end
    $display("lhu 0x4002 rdata_out=%h held", 32'h0000_8001);
  endtask

  // Watchdog of 8: enter ADDR at T+1, bus_err at T+9, late data_ok ignored
  task automatic test_timeout();
    @(negedge clk);  // T
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h6000;
    @(negedge clk);  // T+1
    mem_req = 0; data_sram_addr_ok = 1;
    #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_bus_err_T1: got %b want 0", bus_err); end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      data_sram_addr_ok = 0;
      #1;
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_early_bus_err[T+%0d]: got %b want 0", k, bus_err); end
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL to_stall[T+%0d]: got %b want 1", k, stallreq); end
    end
    @(negedge clk);  // T+9
    #1;
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %b want 1", rdata_valid); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", rdata_out); end
    @(negedge clk);  // T+10
    #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_bus_err_pulse: got %b want 0", bus_err); end
    @(negedge clk);  // T+11: stray data_ok
    data_sram_data_ok = 1; data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL to_late_stall: got %b want 0", stallreq); end
    @(negedge clk);  // T+12
    data_sram_data_ok = 0;
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL to_late_valid: got %b want 0", rdata_valid); end
    $display("lw 0x6000 timed out");
  endtask

  // rst while in DATA, stray data_ok afterwards, then a clean lw
  task automatic test_reset_mid_access();
    @(negedge clk);  // T
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h7000;
    @(negedge clk);  // T+1
    mem_req = 0; data_sram_addr_ok = 1;
    @(negedge clk);  // T+2 (DATA)
    data_sram_addr_ok = 0; rst = 1;
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL rm_in_data: got %b want 1", stallreq); end
    @(negedge clk);  // T+3
    rst = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b want 0", stallreq); end
    checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", data_sram_req); end
    @(negedge clk);  // T+4
    data_sram_data_ok = 0;
    #1;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", rdata_valid); end
    @(negedge clk);
    mem_req = 1; mem_size = 2'b10; mem_addr = 32'h5000;
    @(negedge clk);
    mem_req = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
    #1;
    checks++; if (data_sram_addr !== 32'h5000) begin errors++; $display("FAIL rm_lw_addr: got %h want 00005000", data_sram_addr); end
    @(negedge clk);
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
    #1;
    checks++; if (rdata_valid !== 1'b1 || rdata_out !== 32'h1234_5678) begin
      errors++; $display("FAIL rm_lw_result: got valid=%b %h want valid=1 12345678", rdata_valid, rdata_out);
    end
    $display("lw 0x5000 after reset rdata_out=%h", 32'h1234_5678);
  endtask

  // sb/sh/sw strobe and replication across lanes, immediate acks
  task automatic test_store_lanes();
    logic [1:0]  sz_t [3];
    logic [31:0] ad_t [3], wd_t [3], ew_t [3], ea_t [3];
    logic [3:0]  es_t [3];
    sz_t = '{2'b00, 2'b01, 2'b11};
    ad_t = '{32'h8001, 32'h8000, 32'h8004};
    wd_t = '{32'h1234_565A, 32'hFFFF_BEEF, 32'hDEAD_BEEF};
    ew_t = '{32'h5A5A_5A5A, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
    ea_t = '{32'h8000, 32'h8000, 32'h8004};
    es_t = '{4'b0010, 4'b0011, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req = 1; mem_we = 1; mem_size = sz_t[i]; mem_addr = ad_t[i]; mem_wdata = wd_t[i];
      @(negedge clk);
      mem_req = 0; mem_we = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1;
      #1;
      checks++; if (data_sram_wstrb !== es_t[i]) begin errors++; $display("FAIL st_wstrb[%0d]: got %b want %b", i, data_sram_wstrb, es_t[i]); end
      checks++; if (data_sram_wdata !== ew_t[i]) begin errors++; $display("FAIL st_wdata[%0d]: got %h want %h", i, data_sram_wdata, ew_t[i]); end
      checks++; if (data_sram_addr !== ea_t[i]) begin errors++; $display("FAIL st_addr[%0d]: got %h want %h", i, data_sram_addr, ea_t[i]); end
      @(negedge clk);
      data_sram_addr_ok = 0; data_sram_data_ok = 0;
      #1;
      checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d]: got %b want 1", i, rdata_valid); end
      $display("store %0d addr=%h wstrb=%b", i, ad_t[i], es_t[i]);
    end
  endtask

  initial begin
    test_reset();
    test_lb_min_latency();
    test_sh_waits();
    test_misaligned();
    test_hold();
    test_timeout();
    test_reset_mid_access();
    test_store_lanes();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
